// File: rtl/traffic_sink_if.sv
// Flit delivery and credit return between a router local port and its sink.
// master = router side, slave = sink side.
interface traffic_sink_if #(
  parameter int FLIT_W  = 32,
  parameter int VC_BITS = 2
) ();
  logic              flit_valid;
  logic [FLIT_W-1:0] flit_in;
  logic              credit_valid;
  logic [VC_BITS-1:0] credit_vc;

  modport master (
    output flit_valid,
    output flit_in,
    input  credit_valid,
    input  credit_vc
  );

  modport slave (
    input  flit_valid,
    input  flit_in,
    output credit_valid,
    output credit_vc
  );
endinterface

// File: rtl/traffic_sink.sv
// NoC ejection sink: per-VC framing checks, credit return, run counters.
// Optional payload signature built when TRAFFIC_SINK_SIGNATURE_EN is defined.
module traffic_sink #(
  parameter int FLIT_W  = 32,
  parameter int VC_BITS = 2,
  parameter int NUM_VC  = 4,
  parameter int DEST_W  = 14,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [CNT_W-1:0]  expected_pkts,
  input  logic [DEST_W-1:0] node_addr,
  traffic_sink_if.slave     bus,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  flit_count,
  output logic              err_framing,
  output logic              err_dest,
  output logic              done,
  output logic [15:0]       sig_out
);
  localparam int PAY_W = FLIT_W - 2 - VC_BITS - DEST_W;

  typedef enum logic [1:0] {
    UNARMED,
    RUN,
    DONE
  } run_t;

  typedef enum logic {
    VC_IDLE,
    VC_BODY
  } vc_t;

  run_t              run_st;
  vc_t               vc_st [NUM_VC];
  logic [CNT_W-1:0]  exp_q;

  logic              head;
  logic              tail;
  logic [VC_BITS-1:0] vc;
  logic [DEST_W-1:0] dest;
  logic              take;
  logic              in_body;
  logic              closes;
  logic              frame_err;

  assign head = bus.flit_in[FLIT_W-1];
  assign tail = bus.flit_in[FLIT_W-2];
  assign vc   = bus.flit_in[FLIT_W-3 -: VC_BITS];
  assign dest = bus.flit_in[FLIT_W-3-VC_BITS -: DEST_W];

  // A flit in the init cycle is credited but belongs to no run.
  assign take    = bus.flit_valid && !init
                && (run_st != UNARMED);
  assign in_body = (vc_st[vc] == VC_BODY);
  assign closes  = tail && (head || in_body);
  assign frame_err = (run_st == DONE)
                  || (head ? in_body : !in_body);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      run_st           <= UNARMED;
      exp_q            <= '0;
      pkt_count        <= '0;
      flit_count       <= '0;
      err_framing      <= 1'b0;
      err_dest         <= 1'b0;
      done             <= 1'b0;
      bus.credit_valid <= 1'b0;
      bus.credit_vc    <= '0;
      for (int i = 0; i < NUM_VC; i++)
        vc_st[i] <= VC_IDLE;
    end else begin
      bus.credit_valid <= bus.flit_valid;
      bus.credit_vc    <= bus.flit_valid ? vc : '0;
      if (init) begin
        run_st      <= RUN;
        exp_q       <= expected_pkts;
        pkt_count   <= '0;
        flit_count  <= '0;
        err_framing <= 1'b0;
        err_dest    <= 1'b0;
        done        <= 1'b0;
        for (int i = 0; i < NUM_VC; i++)
          vc_st[i] <= VC_IDLE;
      end else begin
        unique case (run_st)
          RUN: begin
            if (pkt_count == exp_q) begin
              run_st <= DONE;
              done   <= 1'b1;
            end
          end
          default: ;
        endcase
        if (take) begin
          flit_count <= sat_inc(flit_count);
          if (closes)
            pkt_count <= sat_inc(pkt_count);
          if (frame_err)
            err_framing <= 1'b1;
          if (head && dest != node_addr)
            err_dest <= 1'b1;
          // A head on a busy VC abandons the open packet.
          unique case (1'b1)
            head && !tail: vc_st[vc] <= VC_BODY;
            closes:        vc_st[vc] <= VC_IDLE;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef TRAFFIC_SINK_SIGNATURE_EN
  logic [PAY_W-1:0] payload;
  assign payload = bus.flit_in[PAY_W-1:0];

  always_ff @(posedge clk) begin
    if (reset || init)
      sig_out <= '0;
    else if (take && run_st == RUN)
      sig_out <= {sig_out[14:0], sig_out[15]}
               ^ 16'(payload);
  end
`else
  logic unused_payload;
  assign unused_payload = ^bus.flit_in[PAY_W-1:0];
  assign sig_out = '0;
`endif
endmodule

// File: tb/tb_traffic_sink.sv
// Self-checking bench for traffic_sink: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_traffic_sink;
  localparam int FLIT_W  = 32;
  localparam int VC_BITS = 2;
  localparam int NUM_VC  = 4;
  localparam int DEST_W  = 14;
  localparam int CNT_W   = 10;
  localparam int NODE    = 5;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              init;
  logic [CNT_W-1:0]  expected_pkts;
  logic [DEST_W-1:0] node_addr;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  flit_count;
  logic              err_framing;
  logic              err_dest;
  logic              done;
  logic [15:0]       sig_out;

  traffic_sink_if #(.FLIT_W(FLIT_W), .VC_BITS(VC_BITS)) bus ();

  traffic_sink #(
    .FLIT_W(FLIT_W), .VC_BITS(VC_BITS), .NUM_VC(NUM_VC),
    .DEST_W(DEST_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init(init),
    .expected_pkts(expected_pkts),
    .node_addr(node_addr),
    .bus(bus.slave),
    .pkt_count(pkt_count),
    .flit_count(flit_count),
    .err_framing(err_framing),
    .err_dest(err_dest),
    .done(done),
    .sig_out(sig_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(
    input bit h, input bit t, input int vc, input int dst,
    input int pay);
    logic [1:0]  v2 = vc[1:0];
    logic [13:0] d14 = dst[13:0];
    logic [13:0] p14 = pay[13:0];
    return {h, t, v2, d14, p14};
  endfunction

  // Behavioural model: open_len[v] = flits of the open packet on v.
  int          open_len [NUM_VC];
  int          m_pkt, m_flit, target;
  bit          m_ef, m_ed, m_done, armed, m_cv;
  int          m_cvc;
  logic [15:0] m_sig;

  task automatic model_reset();
    m_pkt = 0; m_flit = 0; target = 0;
    m_ef = 0; m_ed = 0; m_done = 0; armed = 0;
    m_cv = 0; m_cvc = 0; m_sig = '0;
    for (int i = 0; i < NUM_VC; i++) open_len[i] = 0;
  endtask

  task automatic model_step(input bit ini, input int ex, input bit v,
                            input logic [FLIT_W-1:0] f);
    bit h = f[31];
    bit t = f[30];
    int vc = int'(f[29:28]);
    int dst = int'(f[27:14]);
    bit was_done = m_done;
    bit reach;
    m_cv = v;
    m_cvc = v ? vc : 0;
    if (ini) begin
      m_pkt = 0; m_flit = 0; m_ef = 0; m_ed = 0; m_done = 0;
      m_sig = '0; armed = 1; target = ex;
      for (int i = 0; i < NUM_VC; i++) open_len[i] = 0;
      return;
    end
    reach = armed && !was_done && (m_pkt == target);
    if (armed && v) begin
      m_flit = (m_flit < CMAX) ? m_flit + 1 : CMAX;
      if (was_done) m_ef = 1;
      if (h) begin
        if (dst != NODE) m_ed = 1;
        if (open_len[vc] > 0) m_ef = 1;
        open_len[vc] = t ? 0 : 1;
        if (t) m_pkt = (m_pkt < CMAX) ? m_pkt + 1 : CMAX;
      end else if (open_len[vc] == 0) begin
        m_ef = 1;
      end else if (t) begin
        open_len[vc] = 0;
        m_pkt = (m_pkt < CMAX) ? m_pkt + 1 : CMAX;
      end else begin
        open_len[vc]++;
      end
      if (!was_done)
        m_sig = {m_sig[14:0], m_sig[15]} ^ {2'b00, f[13:0]};
    end
    if (reach) m_done = 1;
  endtask

  task automatic step(input bit ini, input int ex, input bit v,
                      input logic [FLIT_W-1:0] f);
    @(negedge clk);
    init = ini;
    expected_pkts = ex[CNT_W-1:0];
    bus.flit_valid = v;
    bus.flit_in = f;
    @(posedge clk);
    model_step(ini, ex, v, f);
    #1;
  endtask

  task automatic chk_model();
    chk("m_credit_valid", bus.credit_valid, m_cv);
    if (m_cv) chk("m_credit_vc", bus.credit_vc, m_cvc);
    chk("m_pkt_count", pkt_count, m_pkt);
    chk("m_flit_count", flit_count, m_flit);
    chk("m_err_framing", err_framing, m_ef);
    chk("m_err_dest", err_dest, m_ed);
    chk("m_done", done, m_done);
`ifdef TRAFFIC_SINK_SIGNATURE_EN
    chk("m_sig_out", sig_out, m_sig);
`else
    chk("m_sig_out", sig_out, 0);
`endif
  endtask

  typedef struct {
    bit ini; int ex;
    bit v; bit h; bit t; int vc; int dst; int pay;
    int pkt; int flt; bit ef; bit ed; bit dn; bit cv; int cvc;
    bit cs; int sig;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit ini, input int ex, input bit v,
    input bit h, input bit t, input int vc, input int dst,
    input int pay, input int pkt, input int flt, input bit ef,
    input bit ed, input bit dn, input bit cv, input int cvc,
    input bit cs, input int sig);
    vec_t r;
    r.ini = ini; r.ex = ex; r.v = v; r.h = h; r.t = t;
    r.vc = vc; r.dst = dst; r.pay = pay; r.pkt = pkt;
    r.flt = flt; r.ef = ef; r.ed = ed; r.dn = dn; r.cv = cv;
    r.cvc = cvc; r.cs = cs; r.sig = sig;
    tbl.push_back(r);
  endtask

  initial begin
    reset = 1; init = 0; expected_pkts = '0;
    node_addr = NODE[DEST_W-1:0];
    bus.flit_valid = 0; bus.flit_in = '0;
    model_reset();

    // ini ex  v h t vc dst pay  pkt flt ef ed dn cv cvc cs sig
    add(1, 2, 0,0,0,0,5,0,  0,0,0,0,0,0,0, 0,0);
    add(0, 0, 1,1,1,0,5,1,  1,1,0,0,0,1,0, 0,0);
    add(0, 0, 1,1,1,0,5,2,  2,2,0,0,0,1,0, 0,0);
    add(0, 0, 0,0,0,0,0,0,  2,2,0,0,1,0,0, 0,0);
    add(1, 1, 0,0,0,0,0,0,  0,0,0,0,0,0,0, 0,0);
    add(0, 0, 1,1,0,2,5,3,  0,1,0,0,0,1,2, 0,0);
    add(0, 0, 1,0,0,2,0,4,  0,2,0,0,0,1,2, 0,0);
    add(0, 0, 1,0,1,2,0,5,  1,3,0,0,0,1,2, 0,0);
    add(0, 0, 0,0,0,0,0,0,  1,3,0,0,1,0,0, 0,0);
    add(1, 2, 0,0,0,0,0,0,  0,0,0,0,0,0,0, 0,0);
    add(0, 0, 1,1,0,1,5,6,  0,1,0,0,0,1,1, 0,0);
    add(0, 0, 1,1,0,3,5,7,  0,2,0,0,0,1,3, 0,0);
    add(0, 0, 1,0,1,1,0,8,  1,3,0,0,0,1,1, 0,0);
    add(0, 0, 1,0,1,3,0,9,  2,4,0,0,0,1,3, 0,0);
    add(0, 0, 0,0,0,0,0,0,  2,4,0,0,1,0,0, 0,0);
    add(1, 5, 0,0,0,0,0,0,  0,0,0,0,0,0,0, 0,0);
    add(0, 0, 1,0,0,0,0,0,  0,1,1,0,0,1,0, 0,0);
    add(0, 0, 0,0,0,0,0,0,  0,1,1,0,0,0,0, 0,0);
    add(0, 0, 1,1,0,1,7,0,  0,2,1,1,0,1,1, 0,0);
    add(0, 0, 1,0,1,1,0,0,  1,3,1,1,0,1,1, 0,0);
    add(0, 0, 1,1,0,2,5,0,  1,4,1,1,0,1,2, 0,0);
    add(1, 3, 1,0,0,2,0,0,  0,0,0,0,0,1,2, 1,0);
    add(0, 0, 1,1,1,2,5,1,  1,1,0,0,0,1,2, 1,1);
    add(0, 0, 1,1,1,2,5,2,  2,2,0,0,0,1,2, 1,0);
    add(0, 0, 1,0,1,2,0,0,  2,3,1,0,0,1,2, 0,0);
    add(1, 0, 0,0,0,0,0,0,  0,0,0,0,0,0,0, 0,0);
    add(0, 0, 0,0,0,0,0,0,  0,0,0,0,1,0,0, 0,0);
    add(0, 0, 1,1,1,0,5,0,  1,1,1,0,1,1,0, 0,0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_pkt", pkt_count, 0);
    chk("rst_flit", flit_count, 0);
    chk("rst_errf", err_framing, 0);
    chk("rst_errd", err_dest, 0);
    chk("rst_done", done, 0);
    chk("rst_credit", bus.credit_valid, 0);
    chk("rst_sig", sig_out, 0);

    // Unarmed: credits flow but nothing is counted or flagged.
    step(0, 0, 1, mk(1, 1, 3, 9, 1));
    chk("unarm_cv", bus.credit_valid, 1);
    chk("unarm_cvc", bus.credit_vc, 3);
    chk("unarm_flit", flit_count, 0);
    step(0, 0, 1, mk(0, 1, 0, 0, 2));
    chk("unarm_pkt", pkt_count, 0);
    chk("unarm_errf", err_framing, 0);
    chk("unarm_errd", err_dest, 0);
    step(0, 0, 0, '0);
    chk("unarm_cv_off", bus.credit_valid, 0);

    foreach (tbl[i]) begin
      vec_t r = tbl[i];
      step(r.ini, r.ex, r.v, mk(r.h, r.t, r.vc, r.dst, r.pay));
      chk($sformatf("t%0d_pkt", i), pkt_count, r.pkt);
      chk($sformatf("t%0d_flit", i), flit_count, r.flt);
      chk($sformatf("t%0d_errf", i), err_framing, r.ef);
      chk($sformatf("t%0d_errd", i), err_dest, r.ed);
      chk($sformatf("t%0d_done", i), done, r.dn);
      chk($sformatf("t%0d_cv", i), bus.credit_valid, r.cv);
      if (r.cv) chk($sformatf("t%0d_cvc", i), bus.credit_vc, r.cvc);
`ifdef TRAFFIC_SINK_SIGNATURE_EN
      if (r.cs) chk($sformatf("t%0d_sig", i), sig_out, r.sig);
`else
      chk($sformatf("t%0d_sig", i), sig_out, 0);
`endif
    end

    // Counter saturation at 2**CNT_W-1.
    step(1, CMAX, 0, '0);
    for (int i = 0; i < CMAX + 8; i++)
      step(0, 0, 1, mk(1, 1, i % NUM_VC, NODE, i));
    chk("sat_flit", flit_count, CMAX);
    chk("sat_pkt", pkt_count, CMAX);
    chk("sat_done", done, 1);
    chk("sat_errf", err_framing, 1);
    chk_model();

    // Randomized traffic against the model.
    step(1, $urandom_range(12), 0, '0);
    chk_model();
    for (int i = 0; i < 3000; i++) begin
      bit ini = ($urandom_range(99) == 0);
      bit v = ($urandom_range(9) < 7);
      bit h = ($urandom_range(9) < 4);
      bit t = ($urandom_range(2) != 0);
      int dst = ($urandom_range(19) == 0) ? $urandom_range(15) : NODE;
      step(ini, $urandom_range(12), v,
           mk(h, t, $urandom_range(NUM_VC - 1), dst, $urandom));
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
